// File: rtl/ooops_pipe_slice_pkg.sv
// ============================================================================
// ooops_pipe_slice_pkg : state encodings and SD update-delay macro for the slice
// Rev 1.0 ; optional counter switch: OOOPS_SLICE_STALL_CNT_EN
// ============================================================================
`default_nettype none

`ifndef SD
`define SD
`endif

package ooops_pipe_slice_pkg;

  typedef enum logic [1:0] {
    SLICE_EMPTY = 2'd0,
    SLICE_ONE   = 2'd1,
    SLICE_TWO   = 2'd2
  } slice_state_t;

  localparam int unsigned STALL_CNT_W = 16;

endpackage

`default_nettype wire

// File: rtl/ooops_sat_cnt.sv
// ============================================================================
// ooops_sat_cnt : W-bit up counter that sticks at all-ones, async active-low clear
// Rev 1.0
// ============================================================================
`default_nettype none

module ooops_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] ONE_C = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= `SD '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= `SD cnt + ONE_C;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ooops_pipe_slice.sv
// ============================================================================
// ooops_pipe_slice : two-entry skid buffer with registered valid/ready and flush
// Rev 1.0 ; stall_cnt port present only with OOOPS_SLICE_STALL_CNT_EN
// ============================================================================
`default_nettype none

module ooops_pipe_slice
  import ooops_pipe_slice_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [1:0]    occ
`ifdef OOOPS_SLICE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  slice_state_t state, state_d;
  logic [DW-1:0] skid;
  logic in_fire, out_fire;
  logic load_main, load_skid, main_from_skid;

  // Handshake outputs decode only the state flops, breaking the ready path.
  assign out_valid = (state != SLICE_EMPTY);
  assign in_ready  = (state != SLICE_TWO);
  assign occ       = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= `SD SLICE_EMPTY;
    end else begin
      state <= `SD state_d;
    end
  end

  always_comb begin
    state_d        = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      SLICE_EMPTY: begin
        if (in_fire) begin
          state_d   = SLICE_ONE;
          load_main = 1'b1;
        end
      end
      SLICE_ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_d   = SLICE_TWO;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d   = SLICE_EMPTY;
        end
      end
      SLICE_TWO: begin
        if (out_fire) begin
          state_d        = SLICE_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = SLICE_EMPTY;
    endcase
    // Register loads during a flush only touch entries that become invalid.
    if (flush) begin
      state_d = SLICE_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= `SD '0;
    end else if (load_main) begin
      out_data <= `SD (main_from_skid ? skid : in_data);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid <= `SD '0;
    end else if (load_skid) begin
      skid <= `SD in_data;
    end
  end

`ifdef OOOPS_SLICE_STALL_CNT_EN
  ooops_sat_cnt #(
    .W (STALL_CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );
`endif

endmodule

`default_nettype wire

// File: tb/tb_ooops_pipe_slice.sv
// ============================================================================
// tb_ooops_pipe_slice : queue-model self-checking bench for ooops_pipe_slice
// Rev 1.0 ; counter checks compiled in with OOOPS_SLICE_STALL_CNT_EN
// ============================================================================
`default_nettype none

module tb_ooops_pipe_slice;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  occ;
`ifdef OOOPS_SLICE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int tests = 0;
  int fails = 0;
  bit run_chk = 1'b0;

  // Reference: an ordered queue of held beats plus a plain stall tally.
  logic [31:0] q[$];
  int          m_stall = 0;

  always #5 clk = ~clk;

  ooops_pipe_slice #(.DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occ       (occ)
`ifdef OOOPS_SLICE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_stall = 0;
    end else begin
      if (q.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
      if (flush) begin
        q.delete();
      end else begin
        bit can_take;
        can_take = (q.size() < 2);
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (in_valid && can_take) q.push_back(in_data);
      end
    end
  end

  always @(negedge clk) begin
    if (run_chk && rst_n) begin
      chk("m_out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
      chk("m_in_ready", {31'b0, in_ready}, {31'b0, q.size() < 2});
      chk("m_occ", {30'b0, occ}, q.size());
      if (q.size() > 0) chk("m_out_data", out_data, q[0]);
`ifdef OOOPS_SLICE_STALL_CNT_EN
      chk("m_stall_cnt", {16'b0, stall_cnt}, m_stall);
`endif
    end
  end

  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_a [4];
    exp_a = '{32'hA1, 32'hA2, 32'hA3, 32'hA4};

    #1;
    chk("rst_occ", {30'b0, occ}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_chk = 1'b1;

    for (int i = 0; i < 4; i++) begin
      step(1'b1, exp_a[i], 1'b1, 1'b0);
      chk("stream_data", out_data, exp_a[i]);
      chk("stream_occ", {30'b0, occ}, 32'd1);
      chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'hB1, 1'b0, 1'b0);
    step(1'b1, 32'hB2, 1'b0, 1'b0);
    chk("bp_occ", {30'b0, occ}, 32'd2);
    chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    step(1'b1, 32'hB3, 1'b0, 1'b0);
    chk("bp_hold_data", out_data, 32'hB1);
    step(1'b1, 32'hB3, 1'b1, 1'b0);
    chk("bp_drain1", out_data, 32'hB2);
    chk("bp_ready_back", {31'b0, in_ready}, 32'd1);
    step(1'b1, 32'hB3, 1'b1, 1'b0);
    chk("bp_drain2", out_data, 32'hB3);
    chk("bp_drain2_occ", {30'b0, occ}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("bp_empty", {31'b0, out_valid}, 32'd0);

    step(1'b1, 32'hC1, 1'b0, 1'b0);
    step(1'b1, 32'hC2, 1'b1, 1'b0);
    chk("sim_data", out_data, 32'hC2);
    chk("sim_occ", {30'b0, occ}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    step(1'b1, 32'hD1, 1'b0, 1'b0);
    step(1'b1, 32'hD2, 1'b0, 1'b0);
    step(1'b1, 32'hD3, 1'b0, 1'b1);
    chk("flush_occ", {30'b0, occ}, 32'd0);
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("flush_no_d3", {31'b0, out_valid}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0));
    end

    step(1'b1, 32'hE1, 1'b0, 1'b0);
    step(1'b1, 32'hE2, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_occ", {30'b0, occ}, 32'd0);
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_out_data", out_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'hF1, 1'b1, 1'b0);
    chk("post_rst_accept", out_data, 32'hF1);

`ifdef OOOPS_SLICE_STALL_CNT_EN
    chk("cnt_after_rst", {16'b0, stall_cnt}, 32'd0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("cnt_five", {16'b0, stall_cnt}, 32'd5);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    chk("cnt_flush_kept", {16'b0, stall_cnt}, 32'd6);
    step(1'b1, 32'h5A, 1'b0, 1'b0);
    for (int i = 0; i < 70000; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("cnt_sat", {16'b0, stall_cnt}, 32'hFFFF);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("cnt_no_wrap", {16'b0, stall_cnt}, 32'hFFFF);
`endif

    run_chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
